// File: rtl/lbdr_pkg.sv
// Shared types and constants for the logic-based distributed routing unit.
package lbdr_pkg;

  typedef enum logic [2:0] {
    HEADER = 3'b001,
    BODY   = 3'b010,
    TAIL   = 3'b100
  } flit_e;

  // Bit positions inside the one-hot {L,S,W,E,N} port vector; the deroute
  // code and the Cx bit order share the N/E/W/S numbering.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ROUTED = 1'b1
  } state_e;

  localparam logic [1:0] DR_N = 2'd0;
  localparam logic [1:0] DR_E = 2'd1;
  localparam logic [1:0] DR_W = 2'd2;
  localparam logic [1:0] DR_S = 2'd3;

  // Configuration contents before the first reset.
  localparam logic [7:0] RXY_PWRUP = 8'h3C;
  localparam logic [3:0] CX_PWRUP  = 4'hF;
  localparam logic [1:0] DR_PWRUP  = DR_N;
  localparam int unsigned CUR_PWRUP = 5;

endpackage

// File: rtl/lbdr_dr_if.sv
// Flit-side handshake and routing result between input FIFO, router and allocator.
interface lbdr_dr_if #(
  parameter int unsigned AW = 4
) ();
  logic          empty;
  logic          grant;
  logic [2:0]    flit_id;
  logic [AW-1:0] dst_addr;
  logic [4:0]    port;
  logic          route_vld;
  logic          derouted;
  logic          err;

  modport master (
    output empty, grant, flit_id, dst_addr,
    input  port, route_vld, derouted, err
  );

  modport slave (
    input  empty, grant, flit_id, dst_addr,
    output port, route_vld, derouted, err
  );
endinterface

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR route computation: comparators, minimal terms,
// N>E>W>S priority and deroute fallback.
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int unsigned X_W = 2,
  parameter int unsigned Y_W = 2
) (
  input  logic [X_W+Y_W-1:0] cur_addr,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  logic [7:0]         rxy,
  input  logic [3:0]         cx,
  input  logic [1:0]         dr,
  output logic [4:0]         port,
  output logic               derouted,
  output logic               route_ok
);

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1, l_t;
  logic [3:0]     min_t;

  assign x_cur = cur_addr[X_W-1:0];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_cur = cur_addr[X_W+Y_W-1:X_W];
  assign y_dst = dst_addr[X_W+Y_W-1:X_W];

  // Direction comparators and connectivity-masked minimal terms.
  always_comb begin
    n1 = y_dst < y_cur;
    s1 = y_cur < y_dst;
    e1 = x_cur < x_dst;
    w1 = x_dst < x_cur;
    l_t = ~n1 & ~e1 & ~w1 & ~s1;
    min_t[PORT_N] = cx[PORT_N] & ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1]));
    min_t[PORT_E] = cx[PORT_E] & ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3]));
    min_t[PORT_W] = cx[PORT_W] & ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5]));
    min_t[PORT_S] = cx[PORT_S] & ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7]));
  end

  // One-hot port selection with deroute as last resort.
  always_comb begin
    port     = '0;
    derouted = 1'b0;
    if (l_t) begin
      port[PORT_L] = 1'b1;
    end else if (min_t[PORT_N]) begin
      port[PORT_N] = 1'b1;
    end else if (min_t[PORT_E]) begin
      port[PORT_E] = 1'b1;
    end else if (min_t[PORT_W]) begin
      port[PORT_W] = 1'b1;
    end else if (min_t[PORT_S]) begin
      port[PORT_S] = 1'b1;
    end else if (cx[dr]) begin
      port[dr] = 1'b1;
      derouted = 1'b1;
    end
    route_ok = |port;
  end

endmodule

// File: rtl/lbdr_dr.sv
// LBDR routing unit with deroute: holds the routed port for a whole packet
// and flags protocol/unroutable errors.
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int unsigned X_W = 2,
  parameter int unsigned Y_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic [1:0]         Dr_rst,
  input  logic [X_W+Y_W-1:0] cur_addr_rst,
  lbdr_dr_if.slave           bus
);

  localparam int unsigned AW = X_W + Y_W;

  logic [7:0]    rxy_q = RXY_PWRUP;
  logic [3:0]    cx_q  = CX_PWRUP;
  logic [1:0]    dr_q  = DR_PWRUP;
  logic [AW-1:0] cur_q = AW'(CUR_PWRUP);

  state_e     state_q, state_d;
  logic [4:0] port_q, port_d;
  logic       route_vld_q, route_vld_d;
  logic       derouted_q, derouted_d;
  logic       err_q, err_d;

  logic [4:0] calc_port;
  logic       calc_der, calc_ok;
  logic       consume, route_now;

  lbdr_route_calc #(.X_W(X_W), .Y_W(Y_W)) u_calc (
    .cur_addr (cur_q),
    .dst_addr (bus.dst_addr),
    .rxy      (rxy_q),
    .cx       (cx_q),
    .dr       (dr_q),
    .port     (calc_port),
    .derouted (calc_der),
    .route_ok (calc_ok)
  );

  assign consume = ~bus.empty & bus.grant;

  // Packet FSM: route on header, hold through body, release on tail.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    route_vld_d = route_vld_q;
    derouted_d  = derouted_q;
    err_d       = 1'b0;
    route_now   = 1'b0;
    if (consume) begin
      unique case (state_q)
        IDLE: begin
          if (bus.flit_id == HEADER) begin
            route_now = 1'b1;
          end else if (bus.flit_id == BODY || bus.flit_id == TAIL) begin
            err_d = 1'b1;
          end
        end
        ROUTED: begin
          if (bus.flit_id == HEADER) begin
            err_d     = 1'b1;
            route_now = 1'b1;
          end else if (bus.flit_id == TAIL) begin
            port_d      = '0;
            route_vld_d = 1'b0;
            derouted_d  = 1'b0;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
    end
    // Shared by both states so a header inside a packet re-routes exactly
    // like a fresh one, including falling back to IDLE when unroutable.
    if (route_now) begin
      if (calc_ok) begin
        port_d      = calc_port;
        route_vld_d = 1'b1;
        derouted_d  = calc_der;
        state_d     = ROUTED;
      end else begin
        err_d       = 1'b1;
        port_d      = '0;
        route_vld_d = 1'b0;
        derouted_d  = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  // Configuration load during reset; state and outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q       <= Rxy_rst;
      cx_q        <= Cx_rst;
      dr_q        <= Dr_rst;
      cur_q       <= cur_addr_rst;
      state_q     <= IDLE;
      port_q      <= '0;
      route_vld_q <= 1'b0;
      derouted_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      route_vld_q <= route_vld_d;
      derouted_q  <= derouted_d;
      err_q       <= err_d;
    end
  end

  assign bus.port      = port_q;
  assign bus.route_vld = route_vld_q;
  assign bus.derouted  = derouted_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lbdr_dr.sv
// Self-checking bench for lbdr_dr: a packet-level reference model checked
// every cycle, plus directed literal expectations on two instance widths.
module tb_lbdr_dr;
  import lbdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxy;
  logic [3:0] cx;
  logic [1:0] dr;
  logic [3:0] cur;
  logic [5:0] cur_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lbdr_dr_if #(.AW(4)) ia ();
  lbdr_dr_if #(.AW(6)) ib ();

  lbdr_dr #(.X_W(2), .Y_W(2)) dut_a (
    .clk(clk), .rst(rst), .Rxy_rst(rxy), .Cx_rst(cx), .Dr_rst(dr),
    .cur_addr_rst(cur), .bus(ia.slave)
  );

  lbdr_dr #(.X_W(3), .Y_W(3)) dut_b (
    .clk(clk), .rst(rst), .Rxy_rst(rxy), .Cx_rst(cx), .Dr_rst(dr),
    .cur_addr_rst(cur_b), .bus(ib.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Route from first principles: find productive directions, allow a
  // diagonal one only when its turn bit permits, keep connected ones, take
  // the lowest-numbered, otherwise try the deroute port.
  function automatic void route_model(input int xw, input int cur_i, input int dst_i,
                                      input logic [7:0] r, input logic [3:0] c, input int d,
                                      output logic [4:0] p, output bit dv, output bit ok);
    int xc, yc, xd, yd;
    bit n, s, e, w;
    bit [3:0] want;
    xc = cur_i % (1 << xw);
    yc = cur_i >> xw;
    xd = dst_i % (1 << xw);
    yd = dst_i >> xw;
    n = yd < yc; s = yd > yc; e = xd > xc; w = xd < xc;
    p = '0;
    dv = 1'b0;
    if (!(n || s || e || w)) begin
      p = 5'b10000;
    end else begin
      want[0] = n && (xd == xc || (e ? r[0] : r[1]));
      want[1] = e && (yd == yc || (n ? r[2] : r[3]));
      want[2] = w && (yd == yc || (n ? r[4] : r[5]));
      want[3] = s && (xd == xc || (e ? r[6] : r[7]));
      want = want & c;
      for (int i = 3; i >= 0; i--)
        if (want[i]) p = 5'(1 << i);
      if (p == 0 && c[d]) begin
        p = 5'(1 << d);
        dv = 1'b1;
      end
    end
    ok = (p != 0);
  endfunction

  // Packet-level reference model for instance A.
  logic [7:0] m_rxy;
  logic [3:0] m_cx;
  logic [1:0] m_dr;
  logic [3:0] m_cur;
  logic [4:0] m_port, mp;
  bit m_vld, m_der, m_err, m_live = 1'b0, mdv, mok;

  always @(posedge clk) begin
    if (rst) begin
      m_rxy = rxy; m_cx = cx; m_dr = dr; m_cur = cur;
      m_port = '0; m_vld = 0; m_der = 0; m_err = 0; m_live = 1;
    end else begin
      m_err = 0;
      if (!ia.empty && ia.grant) begin
        case (ia.flit_id)
          HEADER: begin
            route_model(2, int'(m_cur), int'(ia.dst_addr), m_rxy, m_cx, int'(m_dr), mp, mdv, mok);
            if (m_vld) m_err = 1;
            if (mok) begin
              m_port = mp; m_vld = 1; m_der = mdv;
            end else begin
              m_err = 1; m_port = '0; m_vld = 0; m_der = 0;
            end
          end
          BODY: if (!m_vld) m_err = 1;
          TAIL: begin
            if (!m_vld) m_err = 1;
            else begin m_port = '0; m_vld = 0; m_der = 0; end
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_port", 32'(ia.port), 32'(m_port));
      chk("cyc_vld", 32'(ia.route_vld), 32'(m_vld));
      chk("cyc_der", 32'(ia.derouted), 32'(m_der));
      chk("cyc_err", 32'(ia.err), 32'(m_err));
    end
  end

  task automatic drive_a(input bit e, input bit g, input logic [2:0] f, input logic [3:0] d);
    ia.empty = e; ia.grant = g; ia.flit_id = f; ia.dst_addr = d;
    @(posedge clk); #1;
    ia.empty = 1'b1; ia.grant = 1'b0;
  endtask

  task automatic drive_b(input logic [2:0] f, input logic [5:0] d);
    ib.empty = 1'b0; ib.grant = 1'b1; ib.flit_id = f; ib.dst_addr = d;
    @(posedge clk); #1;
    ib.empty = 1'b1; ib.grant = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] r, input logic [3:0] c, input logic [1:0] d);
    rst = 1'b1; rxy = r; cx = c; dr = d;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [4:0] lp;
  bit ldv, lok;

  initial begin
    rst = 1'b1; rxy = 8'h3C; cx = 4'hF; dr = 2'd0; cur = 4'd5; cur_b = 6'o33;
    ia.empty = 1'b1; ia.grant = 1'b0; ia.flit_id = '0; ia.dst_addr = '0;
    ib.empty = 1'b1; ib.grant = 1'b0; ib.flit_id = '0; ib.dst_addr = '0;

    // Pin the reference model with hand-derived routes.
    route_model(2, 5, 15, 8'h3C, 4'hF, 0, lp, ldv, lok);
    chk("model_se_res", 32'(lp), 32'b00010);
    route_model(2, 5, 0, 8'h3C, 4'hF, 0, lp, ldv, lok);
    chk("model_nw_rwn", 32'(lp), 32'b00100);
    route_model(2, 5, 1, 8'h3C, 4'b1110, 1, lp, ldv, lok);
    chk("model_deroute", 32'({ldv, lp}), 32'b100010);
    route_model(2, 5, 1, 8'h3C, 4'b1100, 1, lp, ldv, lok);
    chk("model_unroutable", 32'(lok), 32'd0);

    do_reset(8'h3C, 4'hF, 2'd0);
    chk("rst_port", 32'(ia.port), 32'd0);
    chk("rst_vld", 32'(ia.route_vld), 32'd0);
    chk("rst_err", 32'(ia.err), 32'd0);

    // Wide instance: unsigned 3-bit compare, no wrap.
    drive_b(HEADER, 6'o37);
    chk("wide_east", 32'(ib.port), 32'b00010);
    drive_b(TAIL, 6'o37);
    chk("wide_tail", 32'(ib.port), 32'd0);
    drive_b(HEADER, 6'o30);
    chk("wide_west", 32'(ib.port), 32'b00100);
    drive_b(TAIL, 6'o30);

    // Local delivery and release.
    drive_a(0, 1, HEADER, 4'd5);
    chk("local_port", 32'(ia.port), 32'b10000);
    chk("local_vld", 32'(ia.route_vld), 32'd1);
    drive_a(0, 1, TAIL, 4'd0);
    chk("tail_port", 32'(ia.port), 32'd0);
    chk("tail_vld", 32'(ia.route_vld), 32'd0);

    // Diagonal SE with Res: port held through body, grant gaps and empty gaps.
    drive_a(0, 1, HEADER, 4'hF);
    chk("se_port", 32'(ia.port), 32'b00010);
    drive_a(0, 0, BODY, 4'd0);
    drive_a(0, 1, BODY, 4'd0);
    drive_a(1, 1, BODY, 4'd0);
    drive_a(0, 1, BODY, 4'd0);
    drive_a(0, 1, BODY, 4'd0);
    chk("hold_port", 32'(ia.port), 32'b00010);
    drive_a(0, 1, TAIL, 4'd0);
    drive_a(0, 1, HEADER, 4'd5);
    chk("b2b_port", 32'(ia.port), 32'b10000);
    drive_a(0, 1, TAIL, 4'd0);
    drive_a(0, 1, HEADER, 4'd0);
    chk("nw_port", 32'(ia.port), 32'b00100);
    drive_a(0, 1, TAIL, 4'd0);

    // Deroute to E when N is disconnected.
    do_reset(8'h3C, 4'b1110, 2'd1);
    drive_a(0, 1, HEADER, 4'd1);
    chk("der_port", 32'(ia.port), 32'b00010);
    chk("der_flag", 32'(ia.derouted), 32'd1);
    drive_a(0, 1, TAIL, 4'd0);
    chk("der_clr", 32'(ia.derouted), 32'd0);

    // Deroute port also disconnected: unroutable.
    do_reset(8'h3C, 4'b1100, 2'd1);
    drive_a(0, 1, HEADER, 4'd1);
    chk("unr_err", 32'(ia.err), 32'd1);
    chk("unr_vld", 32'(ia.route_vld), 32'd0);
    drive_a(1, 0, HEADER, 4'd0);
    chk("err_pulse_end", 32'(ia.err), 32'd0);
    drive_a(0, 1, BODY, 4'd0);
    chk("unr_still_idle", 32'(ia.err), 32'd1);

    // Protocol errors.
    do_reset(8'h3C, 4'hF, 2'd0);
    drive_a(0, 1, BODY, 4'd0);
    chk("idle_body_err", 32'(ia.err), 32'd1);
    chk("idle_body_port", 32'(ia.port), 32'd0);
    drive_a(0, 1, HEADER, 4'hF);
    chk("pre_rehdr", 32'(ia.err), 32'd0);
    drive_a(0, 1, HEADER, 4'd5);
    chk("rehdr_err", 32'(ia.err), 32'd1);
    chk("rehdr_port", 32'(ia.port), 32'b10000);
    chk("rehdr_vld", 32'(ia.route_vld), 32'd1);
    drive_a(0, 1, TAIL, 4'd0);

    // Reset mid-packet with a concurrent header and all ports disconnected.
    drive_a(0, 1, HEADER, 4'hF);
    ia.empty = 1'b0; ia.grant = 1'b1; ia.flit_id = HEADER; ia.dst_addr = 4'hF;
    do_reset(8'h3C, 4'h0, 2'd0);
    ia.empty = 1'b1; ia.grant = 1'b0;
    chk("midrst_port", 32'(ia.port), 32'd0);
    chk("midrst_vld", 32'(ia.route_vld), 32'd0);
    drive_a(0, 1, HEADER, 4'hF);
    chk("cx0_err", 32'(ia.err), 32'd1);
    chk("cx0_vld", 32'(ia.route_vld), 32'd0);
    drive_a(0, 1, BODY, 4'd0);
    chk("cx0_body_err", 32'(ia.err), 32'd1);
    drive_a(1, 0, BODY, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
